// File: rtl/dm_stage.sv
// Data-memory stage: load/store against an internal word RAM with a fixed
// multi-cycle access latency, registered into the DM/WB outputs. Optional: DM_MISALIGN_CHECK_EN.
module dm_stage #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_read_in,
  input  logic        Mem_write_in,
  input  logic [31:0] Mem_address,
  input  logic [31:0] Write_data_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic [4:0]  write_reg_in,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] Read_data_out,
  output logic [31:0] ALU_result_out,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic [4:0]  write_reg_out,
  output logic        misalign_out
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [31:0]       ram [DEPTH];

  logic              access;
  logic              load_op;
  logic              misaligned;
  logic              mem_op;
  logic              complete;
  logic              start;
  logic              stall_raw;
  logic [IDX_W-1:0]  word_idx;

  logic              vld_p1;
  logic [31:0]       read_data_p1;
  logic [31:0]       alu_result_p1;
  logic              mem_to_reg_p1;
  logic              reg_write_p1;
  logic [4:0]        write_reg_p1;

  assign access   = Mem_read_in | Mem_write_in;
  assign load_op  = Mem_read_in & ~Mem_write_in;
  assign word_idx = Mem_address[IDX_W+1:2];

`ifdef DM_MISALIGN_CHECK_EN
  assign misaligned = access & (Mem_address[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned access (when checked) behaves like a non-memory op for timing.
  assign mem_op = access & ~misaligned;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    complete  = 1'b0;
    start     = 1'b0;
    stall_raw = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && (LATENCY > 1)) begin
          start     = 1'b1;
          stall_raw = 1'b1;
          state_nxt = BUSY;
          cnt_nxt   = CNT_W'(1);
        end else begin
          complete  = 1'b1;
        end
      end
      BUSY: begin
        stall_raw = (cnt != CNT_LAST);
        cnt_nxt   = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          complete  = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Stall must drop the instant reset is asserted, independent of held inputs.
  assign stall_out = stall_raw & reset;

  // RAM write at completion; gated by reset so an abandoned store never lands.
  always_ff @(posedge clk) begin
    if (reset && complete && mem_op && Mem_write_in) begin
      ram[word_idx] <= Write_data_in;
    end
  end

  // DM/WB register stage (p1)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1        <= 1'b0;
      read_data_p1  <= '0;
      alu_result_p1 <= '0;
      mem_to_reg_p1 <= 1'b0;
      reg_write_p1  <= 1'b0;
      write_reg_p1  <= '0;
    end else if (complete) begin
      vld_p1        <= 1'b1;
      read_data_p1  <= (mem_op && load_op) ? ram[word_idx] : '0;
      alu_result_p1 <= Mem_address;
      mem_to_reg_p1 <= mem_to_reg_in;
      reg_write_p1  <= reg_write_in & ~misaligned;
      write_reg_p1  <= write_reg_in;
    end else if (start) begin
      vld_p1        <= 1'b0;
      reg_write_p1  <= 1'b0;
    end
  end

`ifdef DM_MISALIGN_CHECK_EN
  logic misalign_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_p1 <= 1'b0;
    end else if (complete) begin
      misalign_p1 <= misaligned;
    end
  end

  assign misalign_out = misalign_p1;
`else
  assign misalign_out = 1'b0;
`endif

  assign valid_out      = vld_p1;
  assign Read_data_out  = read_data_p1;
  assign ALU_result_out = alu_result_p1;
  assign mem_to_reg_out = mem_to_reg_p1;
  assign reg_write_out  = reg_write_p1;
  assign write_reg_out  = write_reg_p1;

endmodule

// File: tb/tb_dm_stage.sv
// Scoreboard bench for dm_stage: two instances (LATENCY 2 and 4) share inputs;
// the one under test runs while the other is held in reset.
module tb_dm_stage;

  localparam int DEPTH = 256;

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] alu;
    logic        m2r;
    logic        rw;
    logic [4:0]  wreg;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  logic [1:0] rst_v;

  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        m2r_i = 1'b0;
  logic        rw_i = 1'b0;
  logic [4:0]  wreg_i = '0;

  logic [1:0]        stall_o, valid_o, m2r_o, rw_o, mis_o;
  logic [1:0][31:0]  rd_o, alu_o;
  logic [1:0][4:0]   wreg_o;

  exp_t        q[$];
  logic [31:0] mdl [DEPTH];
  int          act = 0;
  int          lat = 2;
  logic        stall_chk = 1'b0;
  logic        exp_stall = 1'b0;
  int          tests = 0;
  int          fails = 0;

  assign rst_v = {rst1, rst0};

  always #5 clk = ~clk;

  dm_stage #(.DEPTH(DEPTH), .LATENCY(2)) dut2 (
    .clk(clk), .reset(rst0),
    .Mem_read_in(mem_read), .Mem_write_in(mem_write), .Mem_address(addr),
    .Write_data_in(wdata), .mem_to_reg_in(m2r_i), .reg_write_in(rw_i),
    .write_reg_in(wreg_i), .stall_out(stall_o[0]), .valid_out(valid_o[0]),
    .Read_data_out(rd_o[0]), .ALU_result_out(alu_o[0]),
    .mem_to_reg_out(m2r_o[0]), .reg_write_out(rw_o[0]),
    .write_reg_out(wreg_o[0]), .misalign_out(mis_o[0])
  );

  dm_stage #(.DEPTH(DEPTH), .LATENCY(4)) dut4 (
    .clk(clk), .reset(rst1),
    .Mem_read_in(mem_read), .Mem_write_in(mem_write), .Mem_address(addr),
    .Write_data_in(wdata), .mem_to_reg_in(m2r_i), .reg_write_in(rw_i),
    .write_reg_in(wreg_i), .stall_out(stall_o[1]), .valid_out(valid_o[1]),
    .Read_data_out(rd_o[1]), .ALU_result_out(alu_o[1]),
    .mem_to_reg_out(m2r_o[1]), .reg_write_out(rw_o[1]),
    .write_reg_out(wreg_o[1]), .misalign_out(mis_o[1])
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s (dut %0d, t=%0t): got %0h, expected %0h", name, act, $time, got, exp);
    end
  endtask

  // Monitor: compares on every falling clock edge and right after any reset assertion.
  always begin
    @(negedge clk or negedge rst0 or negedge rst1);
    #1;
    if (!rst0 && !rst1) check("queue_drained", 128'(q.size()), 128'd0);
    for (int k = 0; k < 2; k++) begin
      if (!rst_v[k]) begin
        check("reset_outputs_zero",
              {stall_o[k], valid_o[k], rd_o[k], alu_o[k], m2r_o[k], rw_o[k], wreg_o[k], mis_o[k]},
              128'd0);
      end else if (k == act) begin
        if (stall_chk) check("stall", 128'(stall_o[k]), 128'(exp_stall));
        if (valid_o[k]) begin
          if (q.size() == 0) begin
            check("valid_without_expectation", 128'(valid_o[k]), 128'd0);
          end else begin
            exp_t e;
            exp_t g;
            e = q.pop_front();
            g = '{rd: rd_o[k], alu: alu_o[k], m2r: m2r_o[k], rw: rw_o[k], wreg: wreg_o[k], mis: mis_o[k]};
            check("completion", 128'(g), 128'(e));
          end
        end else begin
          check("bubble_reg_write", 128'(rw_o[k]), 128'd0);
        end
      end
    end
  end

  // Present one instruction, record its expected DM/WB result, hold it for its lifetime.
  task automatic issue(input logic rd_en, input logic wr_en, input logic [31:0] a,
                       input logic [31:0] wd, input logic m2r, input logic rw,
                       input logic [4:0] wreg);
    exp_t e;
    int   idx;
    int   n;
    logic acc;
    logic mis;
    mem_read = rd_en; mem_write = wr_en; addr = a; wdata = wd;
    m2r_i = m2r; rw_i = rw; wreg_i = wreg;
    acc = rd_en | wr_en;
    mis = 1'b0;
`ifdef DM_MISALIGN_CHECK_EN
    mis = acc && (a % 4 != 0);
`endif
    idx = int'((a / 4) % DEPTH);
    e = '{rd: 32'h0, alu: a, m2r: m2r, rw: rw & ~mis, wreg: wreg, mis: mis};
    if (acc && !mis) begin
      if (wr_en) mdl[idx] = wd;
      else       e.rd = mdl[idx];
    end
    q.push_back(e);
    n = (acc && !mis) ? lat : 1;
    stall_chk = 1'b1;
    for (int c = 0; c < n; c++) begin
      exp_stall = (c < n - 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rst(input int k, input logic v);
    if (k == 0) rst0 = v;
    else        rst1 = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      act = p;
      lat = (p == 0) ? 2 : 4;
      @(posedge clk);
      #1;
      set_rst(p, 1'b1);

      for (int i = 0; i < DEPTH; i++)
        issue(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0, 5'(i));

      issue(1'b0, 1'b0, 32'h1234, 32'h0, 1'b0, 1'b1, 5'd5);
      issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd7);
      issue(1'b1, 1'b0, 32'h410, 32'h0, 1'b1, 1'b1, 5'd8);
      issue(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 1'b1, 1'b1, 5'd9);
      issue(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 5'd10);
      issue(1'b0, 1'b1, 32'h22, 32'h11112222, 1'b0, 1'b1, 5'd11);
      issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 5'd12);

      // Reset in the middle of a store: RAM must keep its old word.
      mem_read = 1'b0; mem_write = 1'b1; addr = 32'h20; wdata = 32'h5;
      m2r_i = 1'b0; rw_i = 1'b0; wreg_i = 5'd0;
      stall_chk = 1'b1;
      exp_stall = 1'b1;
      @(posedge clk);
      #1;
      stall_chk = 1'b0;
      set_rst(p, 1'b0);
      mem_read = 1'b1; mem_write = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      set_rst(p, 1'b1);
      issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 5'd13);
      issue(1'b0, 1'b1, 32'h20, 32'h5, 1'b0, 1'b0, 5'd0);
      issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 5'd14);

      for (int i = 0; i < 150; i++) begin
        int unsigned sel;
        logic [31:0] a;
        sel = $urandom_range(0, 3);
        a = $urandom;
        if ($urandom_range(0, 1) == 1) a[9:4] = 6'd0;
        issue(sel == 1 || sel == 3, sel >= 2, a, $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      end

      stall_chk = 1'b0;
      #6;
      set_rst(p, 1'b0);
      mem_read = 1'b0; mem_write = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    #20;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
